// File: rtl/bus_share_pkg.sv
// Shared constants for the two-requester bus arbiter: FSM state encoding,
// mux select values and the default bus width.
package bus_share_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_A = 2'd1,
    ST_GRANT_B = 2'd2
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/bus_share_arbiter_mux.sv
// Plain 2-input bus mux: sel = SEL_A passes a, sel = SEL_B passes b.
module bus_share_arbiter_mux
  import bus_share_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = (sel == SEL_B) ? b : a;

endmodule

// File: rtl/bus_share_arbiter.sv
// Round-robin arbiter for two requesters sharing one registered data bus.
// Define BUS_SHARE_HOLD_LIMIT_EN to cap a grant at MAX_HOLD cycles while the other side waits.
module bus_share_arbiter
  import bus_share_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int MAX_HOLD = 4
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic             Req_A,
  input  logic             Req_B,
  input  logic [WIDTH-1:0] Data_A,
  input  logic [WIDTH-1:0] Data_B,
  output logic             Gnt_A,
  output logic             Gnt_B,
  output logic             Op,
  output logic [WIDTH-1:0] Output,
  output logic             Valid,
  output state_t           dbg_state
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("bus_share_arbiter: MAX_HOLD must be in 1..255");
  end

  state_t           state;
  state_t           next_state;
  logic             last_served;
  logic             hold_expired;
  logic             grant_entry;
  logic             mux_sel;
  logic [WIDTH-1:0] mux_out;

`ifdef BUS_SHARE_HOLD_LIMIT_EN
  localparam logic [7:0] HOLD_MAX  = 8'(MAX_HOLD);
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  // hold_cnt counts grant cycles already completed in this tenure, so the
  // current cycle is the MAX_HOLD-th one when it reaches MAX_HOLD-1.
  logic [7:0] hold_cnt;
  assign hold_expired = (hold_cnt >= HOLD_LAST);
`else
  assign hold_expired = 1'b0;
`endif

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE: begin
        if (Req_A && Req_B)
          next_state = (last_served == SEL_B) ? ST_GRANT_A : ST_GRANT_B;
        else if (Req_A)
          next_state = ST_GRANT_A;
        else if (Req_B)
          next_state = ST_GRANT_B;
        else
          next_state = ST_IDLE;
      end
      ST_GRANT_A: begin
        if (Req_A && !(hold_expired && Req_B))
          next_state = ST_GRANT_A;
        else if (Req_B)
          next_state = ST_GRANT_B;
        else
          next_state = ST_IDLE;
      end
      ST_GRANT_B: begin
        if (Req_B && !(hold_expired && Req_A))
          next_state = ST_GRANT_B;
        else if (Req_A)
          next_state = ST_GRANT_A;
        else
          next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign grant_entry = (next_state != ST_IDLE) && (next_state != state);
  assign mux_sel     = (next_state == ST_GRANT_B) ? SEL_B : SEL_A;
  assign dbg_state   = state;

  bus_share_arbiter_mux #(.WIDTH(WIDTH)) u_mux (
    .sel (mux_sel),
    .a   (Data_A),
    .b   (Data_B),
    .y   (mux_out)
  );

  // Outputs follow next_state so grant and data appear one edge after the request.
  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      state       <= ST_IDLE;
      last_served <= SEL_B;
      Gnt_A       <= 1'b0;
      Gnt_B       <= 1'b0;
      Op          <= SEL_A;
      Output      <= '0;
      Valid       <= 1'b0;
    end else begin
      state <= next_state;
      if (grant_entry)
        last_served <= (next_state == ST_GRANT_B) ? SEL_B : SEL_A;
      unique case (next_state)
        ST_GRANT_A: begin
          Gnt_A  <= 1'b1;
          Gnt_B  <= 1'b0;
          Op     <= SEL_A;
          Valid  <= 1'b1;
          Output <= mux_out;
        end
        ST_GRANT_B: begin
          Gnt_A  <= 1'b0;
          Gnt_B  <= 1'b1;
          Op     <= SEL_B;
          Valid  <= 1'b1;
          Output <= mux_out;
        end
        default: begin
          Gnt_A <= 1'b0;
          Gnt_B <= 1'b0;
          Valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef BUS_SHARE_HOLD_LIMIT_EN
  always_ff @(posedge CLK) begin
    if (!Reset_n)
      hold_cnt <= 8'd0;
    else if (grant_entry)
      hold_cnt <= 8'd0;
    else if (state != ST_IDLE && hold_cnt != HOLD_MAX)
      hold_cnt <= hold_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_bus_share_arbiter.sv
// Self-checking bench for bus_share_arbiter: directed scenarios plus random
// traffic checked against an owner/tenure reference model.
module tb_bus_share_arbiter;
  import bus_share_pkg::*;

  localparam int W        = 16;
  localparam int MAX_HOLD = 4;
`ifdef BUS_SHARE_HOLD_LIMIT_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         Reset_n = 1'b0;
  logic         Req_A = 1'b0;
  logic         Req_B = 1'b0;
  logic [W-1:0] Data_A = '0;
  logic [W-1:0] Data_B = '0;
  logic         Gnt_A;
  logic         Gnt_B;
  logic         Op;
  logic [W-1:0] Output;
  logic         Valid;
  state_t       dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  bus_share_arbiter #(.WIDTH(W), .MAX_HOLD(MAX_HOLD)) dut (
    .CLK       (CLK),
    .Reset_n   (Reset_n),
    .Req_A     (Req_A),
    .Req_B     (Req_B),
    .Data_A    (Data_A),
    .Data_B    (Data_B),
    .Gnt_A     (Gnt_A),
    .Gnt_B     (Gnt_B),
    .Op        (Op),
    .Output    (Output),
    .Valid     (Valid),
    .dbg_state (dbg_state)
  );

  // ---------------- reference model ----------------
  // owner: 0 = nobody, 1 = A, 2 = B. held = grant cycles spent in current tenure.
  int           m_owner = 0;
  int           m_last  = 2;
  int           m_held  = 0;
  logic         m_op    = 1'b0;
  logic [W-1:0] m_out   = '0;
  // {gnt_a, gnt_b, valid, op, output}
  logic [W+3:0] exp_q[$];

  task automatic model_step(input logic rn, input logic ra, input logic rb,
                            input logic [W-1:0] da, input logic [W-1:0] db);
    int nxt;
    logic mine, other;
    if (!rn) begin
      m_owner = 0; m_last = 2; m_held = 0; m_op = 1'b0; m_out = '0;
    end else begin
      if (m_owner == 0) begin
        if (ra && rb) nxt = (m_last == 1) ? 2 : 1;
        else if (ra)  nxt = 1;
        else if (rb)  nxt = 2;
        else          nxt = 0;
      end else begin
        mine  = (m_owner == 1) ? ra : rb;
        other = (m_owner == 1) ? rb : ra;
        if (mine && !(HOLD_EN && m_held >= MAX_HOLD && other)) nxt = m_owner;
        else if (other) nxt = 3 - m_owner;
        else nxt = 0;
      end
      if (nxt == 0) m_held = 0;
      else if (nxt != m_owner) begin m_held = 1; m_last = nxt; end
      else m_held = m_held + 1;
      if (nxt == 1) begin m_out = da; m_op = 1'b0; end
      if (nxt == 2) begin m_out = db; m_op = 1'b1; end
      m_owner = nxt;
    end
    exp_q.push_back({m_owner == 1, m_owner == 2, m_owner != 0, m_op, m_out});
  endtask

  // ---------------- driver ----------------
  // Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
  task automatic drive(input logic rn, input logic ra, input logic rb,
                       input logic [W-1:0] da, input logic [W-1:0] db);
    @(negedge CLK);
    Reset_n = rn; Req_A = ra; Req_B = rb; Data_A = da; Data_B = db;
    @(posedge CLK);
    model_step(rn, ra, rb, da, db);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    drive(1'b0, 1'b1, 1'b1, 16'hAAAA, 16'h5555);
    drive(1'b0, 1'b1, 1'b1, 16'hAAAA, 16'h5555);
    n_checks++;
    if ({Gnt_A, Gnt_B, Op, Valid, Output} !== {4'b0000, 16'h0000}) begin
      n_errors++;
      $display("FAIL reset_values: got gnt_a=%b gnt_b=%b op=%b valid=%b out=%h, want all zero",
               Gnt_A, Gnt_B, Op, Valid, Output);
    end
    drive(1'b1, 1'b1, 1'b1, 16'hAAAA, 16'h5555);
    n_checks++;
    if (Gnt_A !== 1'b1 || Gnt_B !== 1'b0 || Output !== 16'hAAAA) begin
      n_errors++;
      $display("FAIL first_tie: got gnt_a=%b gnt_b=%b out=%h, want gnt_a=1 gnt_b=0 out=aaaa",
               Gnt_A, Gnt_B, Output);
    end
    exp_q.delete();
  endtask

  task automatic test_single;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, 16'h0, 16'hBEEF);
      n_checks++;
      if ({Gnt_A, Gnt_B, Op, Valid, Output} !== {4'b0111, 16'hBEEF}) begin
        n_errors++;
        $display("FAIL single_b[%0d]: got gnt_a=%b gnt_b=%b op=%b valid=%b out=%h, want 0 1 1 1 beef",
                 i, Gnt_A, Gnt_B, Op, Valid, Output);
      end
    end
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    n_checks++;
    if ({Gnt_A, Gnt_B, Op, Valid, Output} !== {4'b0010, 16'hBEEF}) begin
      n_errors++;
      $display("FAIL single_idle: got gnt_a=%b gnt_b=%b op=%b valid=%b out=%h, want 0 0 1 0 beef",
               Gnt_A, Gnt_B, Op, Valid, Output);
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back;
    drive(1'b1, 1'b1, 1'b0, 16'h1234, 16'h0);
    n_checks++;
    if ({Gnt_A, Gnt_B, Op, Valid, Output} !== {4'b1001, 16'h1234}) begin
      n_errors++;
      $display("FAIL b2b_a: got gnt_a=%b gnt_b=%b op=%b valid=%b out=%h, want 1 0 0 1 1234",
               Gnt_A, Gnt_B, Op, Valid, Output);
    end
    drive(1'b1, 1'b0, 1'b1, 16'h1234, 16'h5678);
    n_checks++;
    if ({Gnt_A, Gnt_B, Op, Valid, Output} !== {4'b0111, 16'h5678}) begin
      n_errors++;
      $display("FAIL b2b_handover: got gnt_a=%b gnt_b=%b op=%b valid=%b out=%h, want 0 1 1 1 5678",
               Gnt_A, Gnt_B, Op, Valid, Output);
    end
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    exp_q.delete();
  endtask

  task automatic test_round_robin;
    logic exp_a;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    for (int k = 0; k < 3; k++) begin
      exp_a = (k % 2 == 0);
      drive(1'b1, 1'b1, 1'b1, 16'h0A00 + 16'(k), 16'h0B00 + 16'(k));
      n_checks++;
      if (Gnt_A !== exp_a || Gnt_B !== !exp_a || Valid !== 1'b1) begin
        n_errors++;
        $display("FAIL round_robin[%0d]: got gnt_a=%b gnt_b=%b valid=%b, want gnt_a=%b gnt_b=%b valid=1",
                 k, Gnt_A, Gnt_B, Valid, exp_a, !exp_a);
      end
      drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
      n_checks++;
      if (Valid !== 1'b0 || Gnt_A !== 1'b0 || Gnt_B !== 1'b0) begin
        n_errors++;
        $display("FAIL round_robin_idle[%0d]: got gnt_a=%b gnt_b=%b valid=%b, want 0 0 0",
                 k, Gnt_A, Gnt_B, Valid);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_hold_limit;
    logic exp_a;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    for (int i = 0; i < 3 * MAX_HOLD; i++) begin
      exp_a = HOLD_EN ? ((i / MAX_HOLD) % 2 == 0) : 1'b1;
      drive(1'b1, 1'b1, 1'b1, 16'h1000 + 16'(i), 16'h2000 + 16'(i));
      n_checks++;
      if (Gnt_A !== exp_a || Gnt_B !== !exp_a) begin
        n_errors++;
        $display("FAIL hold_limit[%0d]: got gnt_a=%b gnt_b=%b, want gnt_a=%b gnt_b=%b",
                 i, Gnt_A, Gnt_B, exp_a, !exp_a);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_grant;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1'b1, 1'b0, 1'b1, 16'h0, 16'hFFFF);
    drive(1'b1, 1'b0, 1'b1, 16'h0, 16'hFFFF);
    n_checks++;
    if (Gnt_B !== 1'b1 || Output !== 16'hFFFF) begin
      n_errors++;
      $display("FAIL mid_grant_setup: got gnt_b=%b out=%h, want gnt_b=1 out=ffff", Gnt_B, Output);
    end
    drive(1'b0, 1'b1, 1'b1, 16'h0, 16'hFFFF);
    n_checks++;
    if ({Gnt_A, Gnt_B, Op, Valid, Output} !== {4'b0000, 16'h0000}) begin
      n_errors++;
      $display("FAIL mid_grant_reset: got gnt_a=%b gnt_b=%b op=%b valid=%b out=%h, want all zero",
               Gnt_A, Gnt_B, Op, Valid, Output);
    end
    exp_q.delete();
  endtask

  task automatic test_random;
    logic         ra, rb, rn;
    logic [W+3:0] exp;
    logic [W+3:0] got;
    ra = 1'b0; rb = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    exp_q.delete();
    for (int i = 0; i < 400; i++) begin
      // Requests mostly persist so grants span several cycles.
      if ($urandom_range(0, 3) == 0) ra = ~ra;
      if ($urandom_range(0, 3) == 0) rb = ~rb;
      rn = ($urandom_range(0, 59) != 0);
      drive(rn, ra, rb, 16'($urandom), 16'($urandom));
      exp = exp_q.pop_front();
      got = {Gnt_A, Gnt_B, Valid, Op, Output};
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL random[%0d]: got {gnt_a,gnt_b,valid,op,out}=%b_%b_%b_%b_%h, want %b_%b_%b_%b_%h",
                 i, got[W+3], got[W+2], got[W+1], got[W], got[W-1:0],
                 exp[W+3], exp[W+2], exp[W+1], exp[W], exp[W-1:0]);
      end
      n_checks++;
      if (Gnt_A && Gnt_B) begin
        n_errors++;
        $display("FAIL random_exclusive[%0d]: got gnt_a=1 gnt_b=1, want at most one", i);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_round_robin();
    test_hold_limit();
    test_reset_mid_grant();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
